vga_window_timing: RTL and testbench
====================================

VGA_WINDOW_TIMING -- requirements
Module: vga_window_timing

Interface
REQ-001 Parameter H_SYNC, default 120: horizontal sync width in pixel clocks.
REQ-002 Parameter H_BACK, default 64: horizontal back porch in pixel clocks.
REQ-003 Parameter H_DISP, default 800: horizontal active width in pixel clocks.
REQ-004 Parameter H_FRONT, default 56: horizontal front porch in pixel clocks.
REQ-005 Parameters V_SYNC/V_BACK/V_DISP/V_FRONT, defaults 6/23/600/37: vertical equivalents, in lines.
REQ-006 Parameters HS_POL/VS_POL, default 0/0: sync active level, 0 = active-low.
REQ-007 Parameters WIN_X/WIN_Y/WIN_W/WIN_H, default 0/0/200/150: image window origin and size, in active-area pixels.
REQ-008 Parameter RD_LEAD, default 200: pixel clocks before the end of a line at which the next line's read is requested.
REQ-009 Parameter CW, default 12: coordinate and counter width.
REQ-010 clk  in  1  pixel clock; all state changes on its rising edge.
REQ-011 rst  in  1  asynchronous, active-high reset.
REQ-012 run  in  1  level request to generate frames.
REQ-013 x_counter, y_counter  out  CW each  raw horizontal and vertical counters.
REQ-014 xpos, ypos  out  CW each  x_counter-H_SYNC-H_BACK and y_counter-V_SYNC-V_BACK, modulo 2^CW.
REQ-015 VGA_HS, VGA_VS  out  1 each  sync outputs with the polarity set by HS_POL/VS_POL.
REQ-016 de  out  1  active-display enable.
REQ-017 win_de  out  1  enable for pixels inside the image window.
REQ-018 frame_start  out  1  one-cycle pulse at the first pixel of each frame.
REQ-019 line_rd_req  out  1  one-cycle pulse requesting the next window line.
REQ-020 line_rd_row  out  CW  window row index (0..WIN_H-1) qualified by line_rd_req.
REQ-021 frame_cnt  out  16  frame counter.

Function
REQ-022 H_TOTAL is the sum of the four H parameters, V_TOTAL the sum of the four V parameters, H_START is H_SYNC+H_BACK, and V_START is V_SYNC+V_BACK.
REQ-023 FSM states and transitions SHALL be:
- IDLE to RUN when run=1.
- RUN to STOP when run=0.
- STOP to RUN when run=1, with no counter disturbance.
- STOP to IDLE at x_counter=H_TOTAL-1 and y_counter=V_TOTAL-1.
REQ-024 In IDLE the block SHALL hold both counters at 0, both syncs inactive, de/win_de=0 and no pulses.
REQ-025 In RUN and STOP, x_counter SHALL increment every clock and wrap H_TOTAL-1 to 0.
REQ-026 In RUN and STOP, y_counter SHALL increment on each x wrap and wrap V_TOTAL-1 to 0.
REQ-027 The first cycle after leaving IDLE SHALL have counters 0,0.
REQ-028 Syncs SHALL be active when x_counter<H_SYNC (VGA_HS) and when y_counter<V_SYNC (VGA_VS), both combinational from the counters.
REQ-029 de SHALL be 1 iff H_START<=x_counter<H_START+H_DISP and V_START<=y_counter<V_START+V_DISP, combinational.
REQ-030 win_de SHALL equal de AND WIN_X<=xpos<WIN_X+WIN_W AND WIN_Y<=ypos<WIN_Y+WIN_H.
REQ-031 frame_start SHALL be 1 for exactly the cycle with counters 0,0 while not IDLE.
REQ-032 line_rd_req SHALL be registered and assert for one cycle, the cycle after x_counter=H_TOTAL-1-RD_LEAD, when line y_counter+1 is a window line.
REQ-033 line_rd_row SHALL equal y_counter+1-V_START-WIN_Y, registered together with line_rd_req.
REQ-034 The block SHALL produce exactly WIN_H line_rd_req pulses per frame, and none when y_counter=V_TOTAL-1.
REQ-035 Elaboration SHALL fail if WIN_X+WIN_W>H_DISP, if WIN_Y+WIN_H>V_DISP, if RD_LEAD>H_TOTAL-2, if V_START+WIN_Y<1, or if any total does not fit in CW bits.

Reset
REQ-036 While rst=1 the block SHALL be in IDLE with counters 0, line_rd_req=0, line_rd_row=0, frame_cnt=0, and syncs inactive, regardless of run and mid-frame.
REQ-037 After rst deasserts with run=1, the first rising edge SHALL enter RUN.

Configuration
REQ-038 With VGA_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 on each frame_start, wrap at 0xFFFF, and hold in IDLE.
REQ-039 Without VGA_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification (H 3/2/20/3, H_TOTAL=28; V 1/2/8/3, V_TOTAL=14; window 4x3 at (2,1); RD_LEAD=5)
REQ-040 Bench: rst pulse mid-frame -> same cycle counters 0, VGA_HS=VGA_VS=1, de=0, line_rd_req=0.
REQ-041 Bench: run rises in IDLE -> next cycle counters 0,0, frame_start=1, VGA_HS=0, VGA_VS=0; VGA_HS returns to 1 at x_counter=3.
REQ-042 Bench: y_counter=3, x_counter=5 -> de=1, xpos=0, ypos=0; at x_counter=25 -> de=0.
REQ-043 Bench: window rows -> line_rd_req pulses the cycle after x_counter=22 on y_counter=3/4/5 with line_rd_row=0/1/2, and no others in the frame.
REQ-044 Bench: y_counter=4 -> win_de=1 at x_counter 7..10 and 0 at x_counter 6 and 11.
REQ-045 Bench: run dropped mid-frame -> frame completes, IDLE after counters 27,13; with VGA_FRAME_CNT_EN, frame_cnt increments once per frame_start.

Source files
------------

// File: rtl/vga_window_timing.sv
// rtl/vga_window_timing.sv - VGA raster timing with image-window enable and line-read requests
//
// Purpose: generates VGA sync, display enable and raw/active-area coordinates.
//   It also raises a window enable for a sub-rectangle of the active area.
//   A registered request is issued RD_LEAD clocks before the end of each line
//   that precedes a window line, so that line's pixels can be fetched in time.
//   Optional feature macro: VGA_FRAME_CNT_EN enables the 16-bit frame counter.
//   Without it, frame_cnt is tied to 0.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   run          in   level request to generate frames
//   x_counter    out  raw horizontal counter
//   y_counter    out  raw vertical counter
//   xpos, ypos   out  counters relative to the active-area origin (mod 2^CW)
//   VGA_HS/VS    out  sync outputs, polarity from HS_POL/VS_POL
//   de           out  active-display enable
//   win_de       out  enable inside the image window
//   frame_start  out  one-cycle pulse at the first pixel of a frame
//   line_rd_req  out  one-cycle request for the next window line
//   line_rd_row  out  window row for line_rd_req
//   frame_cnt    out  frame counter
module vga_window_timing #(
  parameter int H_SYNC  = 120,
  parameter int H_BACK  = 64,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 56,
  parameter int V_SYNC  = 6,
  parameter int V_BACK  = 23,
  parameter int V_DISP  = 600,
  parameter int V_FRONT = 37,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int WIN_X   = 0,
  parameter int WIN_Y   = 0,
  parameter int WIN_W   = 200,
  parameter int WIN_H   = 150,
  parameter int RD_LEAD = 200,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [CW-1:0] x_counter,
  output logic [CW-1:0] y_counter,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          de,
  output logic          win_de,
  output logic          frame_start,
  output logic          line_rd_req,
  output logic [CW-1:0] line_rd_row,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  if (WIN_X + WIN_W > H_DISP) begin : g_chk_win_x
    $error("vga_window_timing: window exceeds H_DISP");
  end
  if (WIN_Y + WIN_H > V_DISP) begin : g_chk_win_y
    $error("vga_window_timing: window exceeds V_DISP");
  end
  if (RD_LEAD > H_TOTAL - 2) begin : g_chk_lead
    $error("vga_window_timing: RD_LEAD too large for H_TOTAL");
  end
  if (V_START + WIN_Y < 1) begin : g_chk_first_row
    $error("vga_window_timing: first window line must not be line 0");
  end
  if (longint'(H_TOTAL) >= (64'd1 << CW) || longint'(V_TOTAL) >= (64'd1 << CW)) begin : g_chk_cw
    $error("vga_window_timing: totals do not fit in CW bits");
  end

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_START_C = CW'(H_START);
  localparam logic [CW-1:0] V_START_C = CW'(V_START);
  localparam logic [CW-1:0] H_DISP_C  = CW'(H_DISP);
  localparam logic [CW-1:0] V_DISP_C  = CW'(V_DISP);
  localparam logic [CW-1:0] WIN_X_C   = CW'(WIN_X);
  localparam logic [CW-1:0] WIN_Y_C   = CW'(WIN_Y);
  localparam logic [CW-1:0] WIN_W_C   = CW'(WIN_W);
  localparam logic [CW-1:0] WIN_H_C   = CW'(WIN_H);
  localparam logic [CW-1:0] RD_X      = CW'(H_TOTAL - 1 - RD_LEAD);
  localparam logic [CW-1:0] ROW_LO    = CW'(V_START + WIN_Y);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          req_q, req_d;
  logic [CW-1:0] row_q, row_d;

  logic          active;
  logic [CW-1:0] next_y;
  logic [CW-1:0] next_row;
  logic          hs_act;
  logic          vs_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      req_q   <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      row_q   <= row_d;
    end
  end

  assign next_y   = y_q + CW'(1);
  // Unsigned offset from the first window line; values at or above WIN_H
  // (including wrapped negatives) fall outside the window.
  assign next_row = next_y - ROW_LO;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    req_d   = 1'b0;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (run) state_d = RUN;
      end
      RUN, STOP: begin
        if (x_q == H_LAST) begin
          x_d = '0;
          y_d = (y_q == V_LAST) ? '0 : next_y;
        end else begin
          x_d = x_q + CW'(1);
        end

        if (state_q == RUN) begin
          if (!run) state_d = STOP;
        end else if (run) begin
          state_d = RUN;
        end else if (x_q == H_LAST && y_q == V_LAST) begin
          state_d = IDLE;
        end

        // Request the following line while the current one still has
        // RD_LEAD clocks to run; the last line of a frame never requests.
        if (x_q == RD_X && y_q != V_LAST && next_row < WIN_H_C) begin
          req_d = 1'b1;
          row_d = next_row;
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  assign active      = (state_q != IDLE);
  assign x_counter   = x_q;
  assign y_counter   = y_q;
  assign xpos        = x_q - H_START_C;
  assign ypos        = y_q - V_START_C;

  assign hs_act      = active && (x_q < H_SYNC_C);
  assign vs_act      = active && (y_q < V_SYNC_C);
  assign VGA_HS      = (HS_POL != 0) ? hs_act : !hs_act;
  assign VGA_VS      = (VS_POL != 0) ? vs_act : !vs_act;

  // Range checks use wrapped unsigned offsets so a zero lower bound needs
  // no special case.
  assign de          = active && (xpos < H_DISP_C) && (ypos < V_DISP_C);
  assign win_de      = de && ((xpos - WIN_X_C) < WIN_W_C) && ((ypos - WIN_Y_C) < WIN_H_C);
  assign frame_start = active && (x_q == '0) && (y_q == '0);

  assign line_rd_req = req_q;
  assign line_rd_row = row_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
    end else if (frame_start) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_window_timing.sv
// tb/tb_vga_window_timing.sv - directed self-checking bench for vga_window_timing
module tb_vga_window_timing;

  localparam int CW = 8;
`ifdef VGA_FRAME_CNT_EN
  localparam int FCE = 1;
`else
  localparam int FCE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [CW-1:0] x_counter, y_counter, xpos, ypos;
  logic          VGA_HS, VGA_VS, de, win_de, frame_start, line_rd_req;
  logic [CW-1:0] line_rd_row;
  logic [15:0]   frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  int ex, ey, n_req, n_frames;

  vga_window_timing #(
    .H_SYNC(3), .H_BACK(2), .H_DISP(20), .H_FRONT(3),
    .V_SYNC(1), .V_BACK(2), .V_DISP(8), .V_FRONT(3),
    .HS_POL(0), .VS_POL(0),
    .WIN_X(2), .WIN_Y(1), .WIN_W(4), .WIN_H(3),
    .RD_LEAD(5), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .x_counter(x_counter), .y_counter(y_counter),
    .xpos(xpos), .ypos(ypos),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .de(de), .win_de(win_de), .frame_start(frame_start),
    .line_rd_req(line_rd_req), .line_rd_row(line_rd_row),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected values follow H 3/2/20/3 (total 28), V 1/2/8/3 (total 14),
  // window 4x3 at (2,1), request at x=22 so the pulse is seen at x=23.
  task automatic run_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("x_counter@%0d,%0d", ex, ey), x_counter, ex);
      check($sformatf("y_counter@%0d,%0d", ex, ey), y_counter, ey);
      check($sformatf("VGA_HS@%0d,%0d", ex, ey), VGA_HS, ex >= 3);
      check($sformatf("VGA_VS@%0d,%0d", ex, ey), VGA_VS, ey >= 1);
      check($sformatf("de@%0d,%0d", ex, ey), de, (ex >= 5 && ex < 25 && ey >= 3 && ey < 11));
      check($sformatf("win_de@%0d,%0d", ex, ey), win_de, (ex >= 7 && ex < 11 && ey >= 4 && ey < 7));
      check($sformatf("frame_start@%0d,%0d", ex, ey), frame_start, (ex == 0 && ey == 0));
      check($sformatf("line_rd_req@%0d,%0d", ex, ey), line_rd_req, (ex == 23 && ey >= 3 && ey <= 5));
      if (ex == 23 && ey >= 3 && ey <= 5)
        check($sformatf("line_rd_row@%0d", ey), line_rd_row, ey - 3);
      if (ex == 5 && ey == 3) begin
        check("xpos@5,3", xpos, 0);
        check("ypos@5,3", ypos, 0);
      end
      if (ex == 1)
        check($sformatf("frame_cnt@1,%0d", ey), frame_cnt, FCE * n_frames);
      if (line_rd_req) n_req++;
      if (ex == 0 && ey == 0) n_frames++;
      @(posedge clk);
      @(negedge clk);
      ex++;
      if (ex == 28) begin
        ex = 0;
        ey = (ey == 13) ? 0 : ey + 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", x_counter, 0);
    check("rst_y", y_counter, 0);
    check("rst_hs", VGA_HS, 1);
    check("rst_vs", VGA_VS, 1);
    check("rst_de", de, 0);
    check("rst_req", line_rd_req, 0);
    check("rst_row", line_rd_row, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_fs", frame_start, 0);

    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_x", x_counter, 0);
    check("idle_fs", frame_start, 0);
    check("idle_hs", VGA_HS, 1);

    // Frame 1: continuous run.
    run = 1'b1;
    @(negedge clk);
    ex = 0; ey = 0; n_frames = 0; n_req = 0;
    run_cyc(392);
    check("req_count_f1", n_req, 3);

    // Frame 2: stop, resume, stop again; counters must not be disturbed.
    n_req = 0;
    run_cyc(140);
    run = 1'b0;
    run_cyc(28);
    run = 1'b1;
    run_cyc(56);
    run = 1'b0;
    run_cyc(168);
    check("req_count_f2", n_req, 3);
    check("end_idle_x", x_counter, 0);
    check("end_idle_y", y_counter, 0);
    check("end_idle_fs", frame_start, 0);
    check("end_idle_hs", VGA_HS, 1);
    check("end_idle_vs", VGA_VS, 1);
    check("end_idle_de", de, 0);
    check("end_fcnt", frame_cnt, FCE * 2);
    repeat (3) @(negedge clk);
    check("hold_idle_x", x_counter, 0);
    check("hold_fcnt", frame_cnt, FCE * 2);

    // Reset in the middle of a frame while a request pulse is up.
    run = 1'b1;
    @(negedge clk);
    ex = 0; ey = 0;
    run_cyc(5 * 28 + 23);
    check("pre_rst_req", line_rd_req, 1);
    check("pre_rst_de", de, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_x", x_counter, 0);
    check("mid_rst_y", y_counter, 0);
    check("mid_rst_hs", VGA_HS, 1);
    check("mid_rst_vs", VGA_VS, 1);
    check("mid_rst_de", de, 0);
    check("mid_rst_req", line_rd_req, 0);
    check("mid_rst_row", line_rd_row, 0);
    check("mid_rst_fcnt", frame_cnt, 0);
    n_frames = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_x", x_counter, 0);
    check("restart_y", y_counter, 0);
    check("restart_fs", frame_start, 1);
    check("restart_hs", VGA_HS, 0);
    check("restart_vs", VGA_VS, 0);
    ex = 0; ey = 0;
    run_cyc(28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
